// File: rtl/ldpc_enc.sv
// Systematic quasi-cyclic LDPC encoder: passes K info sub-blocks through and
// appends C parity sub-blocks computed by dual-diagonal back-substitution.
module ldpc_enc #(
  parameter int R       = 24,
  parameter int C       = 12,
  parameter int D       = 96,
  parameter int shift_w = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [C*R*shift_w-1:0]   mtx,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [D-1:0]             in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [D-1:0]             out_data,
  output logic                     out_last,
  output logic                     busy
);

  localparam int K  = R - C;
  localparam int MW = C * R * shift_w;
  localparam int CW = $clog2(R + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SUM, PAR} state_t;

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_j, w_j_nx;
  logic [CW-1:0]   r_m, w_m_nx;
  logic [CW-1:0]   w_jsel;
  logic [MW-1:0]   r_mtx, w_mtx;
  logic [D-1:0]    r_lambda [C];
  logic [D-1:0]    r_p0, r_prev;
  logic [D-1:0]    w_p0, w_par;
  logic            r_out_valid, r_out_last;
  logic [D-1:0]    r_out_data;
  logic            w_free, w_drain, w_accept, w_first;
  logic            w_emit_p0, w_emit_par;

  // rot(x,s)[k] = x[(k+s) mod D]; all-ones or any shift >= D is a null block.
  function automatic logic [D-1:0] rot(input logic [D-1:0] x, input logic [shift_w-1:0] s);
    logic [2*D-1:0] dbl;
    dbl = {x, x} >> s;
    if ((s == '1) || (32'(s) >= 32'(D))) return '0;
    return dbl[D-1:0];
  endfunction

  function automatic logic [shift_w-1:0] entry(input logic [MW-1:0] m,
                                               input int unsigned row,
                                               input int unsigned col);
    return m[(row * R + col) * shift_w +: shift_w];
  endfunction

  assign w_free   = ~r_out_valid | out_ready;
  // PAR with r_m == C: last parity beat sits in the output register awaiting drain.
  assign w_drain  = (r_state == PAR) && (r_m == CW'(C));
  assign in_ready = ~rst & w_free & ((r_state == IDLE) | (r_state == LOAD) | w_drain);
  assign w_accept = in_valid & in_ready;
  assign w_first  = w_accept & (r_state != LOAD);
  assign w_mtx    = w_first ? mtx : r_mtx;
  assign w_jsel   = w_first ? '0 : r_j;

  assign w_emit_p0  = (r_state == SUM) & w_free;
  assign w_emit_par = (r_state == PAR) & ~w_drain & w_free;

  always_comb begin
    w_p0 = '0;
    for (int unsigned i = 0; i < C; i++) w_p0 = w_p0 ^ r_lambda[i];
  end

  // p1 has no predecessor term; later blocks chain off the previous parity.
  always_comb begin
    w_par = (r_m == CW'(1)) ? '0 : r_prev;
    for (int unsigned i = 0; i < C; i++) begin
      if (CW'(i + 1) == r_m) w_par = w_par ^ r_lambda[i] ^ rot(r_p0, entry(r_mtx, i, K));
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_j_nx     = r_j;
    w_m_nx     = r_m;
    case (r_state)
      IDLE, LOAD: begin
        if (w_accept) begin
          w_j_nx     = (r_state == IDLE) ? CW'(1) : r_j + 1'b1;
          w_state_nx = (w_j_nx == CW'(K)) ? SUM : LOAD;
        end
      end
      SUM: begin
        if (w_free) begin
          w_state_nx = PAR;
          w_m_nx     = CW'(1);
        end
      end
      PAR: begin
        if (w_drain) begin
          if (out_ready) begin
            if (w_accept) begin
              w_j_nx     = CW'(1);
              w_state_nx = (K == 1) ? SUM : LOAD;
            end else begin
              w_state_nx = IDLE;
            end
          end
        end else if (w_free) begin
          w_m_nx = r_m + 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_j         <= '0;
      r_m         <= '0;
      r_mtx       <= '0;
      r_p0        <= '0;
      r_prev      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      for (int unsigned i = 0; i < C; i++) r_lambda[i] <= '0;
    end else begin
      r_state <= w_state_nx;
      r_j     <= w_j_nx;
      r_m     <= w_m_nx;
      if (w_first) r_mtx <= mtx;

      for (int unsigned i = 0; i < C; i++) begin
        if (w_accept)
          r_lambda[i] <= (w_first ? '0 : r_lambda[i]) ^ rot(in_data, entry(w_mtx, i, 32'(w_jsel)));
        else if (w_drain & out_ready)
          r_lambda[i] <= '0;
      end

      if (w_emit_p0) begin
        r_p0   <= w_p0;
        r_prev <= w_p0;
      end
      if (w_emit_par) r_prev <= w_par;

      if (w_accept) begin
        r_out_data  <= in_data;
        r_out_valid <= 1'b1;
        r_out_last  <= 1'b0;
      end else if (w_emit_p0) begin
        r_out_data  <= w_p0;
        r_out_valid <= 1'b1;
        r_out_last  <= (C == 1);
      end else if (w_emit_par) begin
        r_out_data  <= w_par;
        r_out_valid <= 1'b1;
        r_out_last  <= (r_m == CW'(C - 1));
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = (r_state != IDLE);

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (r_out_valid && !out_ready) |=> (r_out_valid && $stable(r_out_data) && $stable(r_out_last)));

endmodule
